// File: rtl/gbe_rx_status_pkg.sv
// Shared definitions for the gbe0 RX status sequencer: sequencer states,
// control-word bit positions, snapshot select encodings and status-word
// field positions.
package gbe_rx_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CLEAR   = 2'd2
  } state_t;

  // ctrl word bit positions
  localparam int unsigned CTRL_SNAP   = 0;
  localparam int unsigned CTRL_CLR    = 1;
  localparam int unsigned CTRL_AUTO   = 2;
  localparam int unsigned CTRL_SEL_LO = 4;
  localparam int unsigned CTRL_SEL_HI = 5;

  // snapshot / counter select encodings
  localparam logic [1:0] SEL_GOOD  = 2'd0;
  localparam logic [1:0] SEL_BAD   = 2'd1;
  localparam logic [1:0] SEL_OVR   = 2'd2;
  localparam logic [1:0] SEL_BEATS = 2'd3;

  // status_word field positions
  localparam int unsigned SW_SEL_HI = 31;
  localparam int unsigned SW_SEL_LO = 30;
  localparam int unsigned SW_ACK    = 29;
  localparam int unsigned SW_BUSY   = 28;
  localparam int unsigned SW_CNT_W  = 28;

endpackage

// File: rtl/gbe_rx_event_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : restart the count; the same-cycle event is kept (loads 0 or 1)
//   count      : current count, sticks at all-ones
module gbe_rx_event_counter #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= {{(CNT_W-1){1'b0}}, inc};
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gbe_rx_status_sequencer.sv
// Counts gbe0 RX events and sequences coherent snapshots of the counts onto
// the software status register.
//   user_clk, user_rst_n : clock, asynchronous active-low reset
//   rx_valid, rx_eof     : RX beat valid / last beat of frame
//   rx_bad_frame         : frame bad, sampled on a valid eof
//   rx_overrun           : overrun level flag, rising edges are counted
//   ctrl                 : bit0 snapshot toggle, bit1 clear (rising edge),
//                          bit2 auto enable, bits[5:4] word select
//   status_word          : {select echo, ack toggle, busy, snapshot count}
module gbe_rx_status_sequencer
  import gbe_rx_status_pkg::*;
#(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned PERIOD_W    = 32,
  parameter int unsigned AUTO_PERIOD = 156250000
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        rx_valid,
  input  logic        rx_eof,
  input  logic        rx_bad_frame,
  input  logic        rx_overrun,
  input  logic [31:0] ctrl,
  output logic [31:0] status_word
);

  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(AUTO_PERIOD - 1);

  state_t              state, state_nxt;
  logic [1:0]          ctrl_q;
  logic                ovr_q;
  logic                snap_pend, snap_pend_nxt;
  logic                auto_pend, auto_pend_nxt;
  logic                clr_pend, clr_pend_nxt;
  logic                ack, ack_nxt;
  logic                busy_nxt;
  logic [PERIOD_W-1:0] per_cnt, per_nxt;
  logic                manual_req, clr_req, auto_fire, cap_start;
  logic                frame_end, clr_live;
  logic [3:0]          inc;
  logic [CNT_W-1:0]    live [4];
  logic [CNT_W-1:0]    snap [4];
  logic [1:0]          sel_nxt;
  logic [CNT_W-1:0]    sel_cnt;
  logic [31:0]         status_nxt;
  logic                unused_ctrl;

  assign unused_ctrl = ^{ctrl[31:6], ctrl[3]};

  assign manual_req = ctrl[CTRL_SNAP] ^ ctrl_q[0];
  assign clr_req    = ctrl[CTRL_CLR] & ~ctrl_q[1];
  assign auto_fire  = ctrl[CTRL_AUTO] && (per_cnt == PERIOD_LAST);
  assign frame_end  = rx_valid & rx_eof;
  assign clr_live   = (state == ST_CLEAR);
  assign sel_nxt    = ctrl[CTRL_SEL_HI:CTRL_SEL_LO];

  always_comb begin
    inc            = '0;
    inc[SEL_GOOD]  = frame_end & ~rx_bad_frame;
    inc[SEL_BAD]   = frame_end & rx_bad_frame;
    inc[SEL_OVR]   = rx_overrun & ~ovr_q;
    inc[SEL_BEATS] = rx_valid;
  end

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    gbe_rx_event_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (user_clk),
      .rst_n (user_rst_n),
      .inc   (inc[i]),
      .clr   (clr_live),
      .count (live[i])
    );
  end

  // Requests are acted on combinationally from IDLE so a capture starts the
  // cycle after the request, while the pending flag records it in parallel.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (snap_pend || auto_pend || manual_req || auto_fire) begin
          state_nxt = ST_CAPTURE;
        end else if (clr_pend || clr_req) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CAPTURE: state_nxt = clr_pend ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    snap_pend_nxt = ((state == ST_CAPTURE) ? 1'b0 : snap_pend) | manual_req;
    auto_pend_nxt = ((state == ST_CAPTURE) ? 1'b0 : auto_pend) | auto_fire;
    clr_pend_nxt  = ((state == ST_CLEAR)   ? 1'b0 : clr_pend)  | clr_req;
    ack_nxt       = ((state == ST_CAPTURE) && snap_pend) ? ctrl_q[0] : ack;
    busy_nxt      = (state_nxt != ST_IDLE) || snap_pend_nxt || auto_pend_nxt
                    || clr_pend_nxt;
  end

  // The period restarts when a capture is launched, so a self-triggered
  // capture does not stretch the period by its own CAPTURE cycle.
  assign cap_start = (state == ST_IDLE) && (state_nxt == ST_CAPTURE);

  always_comb begin
    if (!ctrl[CTRL_AUTO]) begin
      per_nxt = '0;
    end else if (auto_fire || cap_start) begin
      per_nxt = '0;
    end else begin
      per_nxt = per_cnt + 1'b1;
    end
  end

  // status_word is registered from next-state values so it tracks the
  // internal registers with no extra cycle of lag.
  always_comb begin
    sel_cnt = (state == ST_CAPTURE) ? live[sel_nxt] : snap[sel_nxt];
    status_nxt                      = '0;
    status_nxt[SW_SEL_HI:SW_SEL_LO] = sel_nxt;
    status_nxt[SW_ACK]              = ack_nxt;
    status_nxt[SW_BUSY]             = busy_nxt;
    status_nxt[SW_CNT_W-1:0]        = SW_CNT_W'(sel_cnt);
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state       <= ST_IDLE;
      ctrl_q      <= '0;
      ovr_q       <= 1'b0;
      snap_pend   <= 1'b0;
      auto_pend   <= 1'b0;
      clr_pend    <= 1'b0;
      ack         <= 1'b0;
      per_cnt     <= '0;
      status_word <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        snap[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      ctrl_q      <= {ctrl[CTRL_CLR], ctrl[CTRL_SNAP]};
      ovr_q       <= rx_overrun;
      snap_pend   <= snap_pend_nxt;
      auto_pend   <= auto_pend_nxt;
      clr_pend    <= clr_pend_nxt;
      ack         <= ack_nxt;
      per_cnt     <= per_nxt;
      status_word <= status_nxt;
      if (state == ST_CAPTURE) begin
        for (int unsigned i = 0; i < 4; i++) begin
          snap[i] <= live[i];
        end
      end
    end
  end

endmodule

// File: doc/gbe_rx_status_sequencer.md
# gbe_rx_status_sequencer

Counts 10GbE receive events in the `user_clk` domain and sequences coherent snapshots of those counts onto the single 32-bit software status register that feeds `user_data_in`. Software controls it through one 32-bit ppc2simulink control word. A toggle handshake requests a snapshot, a rising edge clears the counters, and a field selects which snapshot word is presented. An optional periodic auto-snapshot is provided. The block sits between the gbe0 RX datapath and the rx status register.

## Interface
- `CNT_W`, 28: live and snapshot counter width, legal range 8..28; narrower values are zero-extended into the count field.
- `PERIOD_W`, 32: auto-period counter width.
- `AUTO_PERIOD`, 156250000: cycles between auto snapshots (1 s at 156.25 MHz); must be ≥ 4.
- `user_clk` in 1: single clock; all logic on its rising edge.
- `user_rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: RX data beat valid.
- `rx_eof` in 1: last beat of a frame; qualified by `rx_valid`.
- `rx_bad_frame` in 1: frame bad; sampled with `rx_valid && rx_eof`.
- `rx_overrun` in 1: overrun level flag.
- `ctrl` in 32: software control word, synchronous to `user_clk`.
  - bit0 = snapshot toggle.
  - bit1 = clear.
  - bit2 = auto enable.
  - bits[5:4] = word select.
  - Other bits are ignored.
- `status_word` out 32: drives `user_data_in`. Field layout:
  - [31:30] = select echo.
  - [29] = ack toggle.
  - [28] = busy.
  - [27:0] = selected snapshot count.

## Operation
- Live counters, all saturating at 2^CNT_W−1:
  - sel 0 GOOD: `rx_valid && rx_eof && !rx_bad_frame`.
  - sel 1 BAD: `rx_valid && rx_eof && rx_bad_frame`.
  - sel 2 OVR: each rising edge of `rx_overrun`, detected against a registered copy.
  - sel 3 BEATS: each `rx_valid`.
- `ctrl_q` registers `ctrl`.
  - Manual request: `ctrl[0] != ctrl_q[0]`.
  - Clear request: `ctrl[1] && !ctrl_q[1]`.
- Pending flags `snap_pend` and `clr_pend` are set by the requests and cleared when their state executes.
- Auto mode: while `ctrl[2]`=1, the period counter counts up. On reaching `AUTO_PERIOD`−1 it sets `auto_pend` and reloads to 0. It also reloads on any CAPTURE. While `ctrl[2]`=0 it is held at 0.
- FSM states are IDLE, CAPTURE and CLEAR.
- From IDLE:
  - Any snapshot pending (manual or auto) → CAPTURE.
  - Else `clr_pend` → CLEAR.
- CAPTURE:
  - All four snapshot registers load the live counter values simultaneously.
  - If the capture was manually requested, the ack bit takes `ctrl_q[0]`.
  - Next state is CLEAR if `clr_pend`, else IDLE.
- CLEAR:
  - Each live counter loads its same-cycle increment (0 or 1), so no events are lost.
  - Next state is IDLE.
- Simultaneous manual and auto requests are served by one CAPTURE, and the ack still toggles.
- Simultaneous snapshot and clear: CAPTURE runs before CLEAR, so the snapshot holds the pre-clear values.
- A request arriving while busy is held pending and served on return to IDLE. Repeated toggles while pending collapse into one capture.
- Busy = (state != IDLE) || any pending flag.
- Reset: all counters, snapshots, pending flags, `ctrl_q`, the ack bit, the period counter and `status_word` go to 0; the state goes to IDLE. If `ctrl[0]`=1 on reset exit, exactly one capture is triggered.
- Reset asserted mid-CAPTURE or mid-CLEAR aborts the operation immediately; no partial snapshot survives.

## Timing
- Request visible on `ctrl` at cycle N → pending at N+1 → CAPTURE at N+1 if IDLE (decision made on the combinational request).
- Captured values include events through cycle N. Events at N+1 land in the live counters only.
- Ack bit and busy=0 appear on `status_word` at N+2 when no clear follows. With a coincident clear, busy=0 appears at N+3.
- A change of `ctrl[5:4]` at N updates `status_word` at N+1, registered.
- A snapshot load at CAPTURE cycle M is visible in `status_word` at M+1.

## Structure
- Package `gbe_rx_status_pkg` holds:
  - the state enum;
  - the `ctrl` bit indices;
  - the select encodings GOOD/BAD/OVR/BEATS;
  - the `status_word` field positions.
- Sub-module `gbe_rx_event_counter` (CNT_W): a saturating counter with an increment input and a clear-with-load-increment input, instantiated 4×.

## Test plan
- Reset, 10 good frames, 3 bad frames, toggle `ctrl[0]`, then sel 0 and sel 1:
  - `status_word`[27:0] reads 10 and 3;
  - ack bit = 1;
  - busy returns to 0 two cycles after the toggle.
- `rx_overrun` high for 5 cycles, twice, plus 100 beats; snapshot:
  - OVR = 2, BEATS = 100.
- Toggle and clear in the same cycle with GOOD = 7:
  - snapshot GOOD = 7;
  - live counter restarts at 0, or 1 if a good eof coincides with the CLEAR cycle;
  - next snapshot equals the events since the clear.
- Force the GOOD count to 2^CNT_W−1 with CNT_W=8, then 5 more good frames:
  - snapshot reads 255.
- Auto mode with AUTO_PERIOD=16:
  - a snapshot every 16 cycles, ack unchanged;
  - a manual toggle coinciding with an auto request gives one capture and one ack flip.
- Assert `user_rst_n`=0 during CAPTURE:
  - all outputs read 0 next edge;
  - `ctrl[0]`=1 held across reset gives exactly one capture after release.
